// File: rtl/mod_wb_sequencer_pkg.sv
// Shared pipeline definitions: opcode constants, architectural register indices, write-back state enum.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
package mod_wb_sequencer_pkg;

  // Opcodes the write-back stage treats specially; anything else is a plain rm-destination write.
  localparam logic [7:0] OP_MUL_F7    = 8'hF7;  // 128-bit product: low -> RAX, high -> RDX
  localparam logic [7:0] OP_PUSH_FF   = 8'hFF;  // push: RSP -= 8, store handled by memory stage
  localparam logic [7:0] OP_STORE_89  = 8'h89;  // register-to-memory move, no register write
  localparam logic [7:0] OP_LOAD_8B   = 8'h8B;  // move into the reg-field register

  // Architectural register indices.
  localparam logic [3:0] REG_RAX = 4'd0;
  localparam logic [3:0] REG_RDX = 4'd2;
  localparam logic [3:0] REG_RSP = 4'd4;

  // Stack step applied by a push.
  localparam logic [63:0] PUSH_STEP = 64'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR0,
    ST_WR1,
    ST_STORE_WAIT,
    ST_HALT
  } wb_state_e;

  // Opcode class resolved once at accept so the write states never re-decode.
  typedef enum logic [2:0] {
    K_MUL,
    K_PUSH,
    K_STORE,
    K_LOAD,
    K_OTHER
  } op_kind_e;

  // Everything the sequencer needs to remember about an accepted entry.
  typedef struct packed {
    op_kind_e    kind;
    logic [3:0]  reg_byte;
    logic [3:0]  rm_byte;
    logic [63:0] alu_result;
    logic [63:0] alu_ext_result;
    logic        sim_end;
  } wb_entry_t;

  function automatic op_kind_e decode_op(input logic [7:0] op);
    op_kind_e k;
    case (op)
      OP_MUL_F7:   k = K_MUL;
      OP_PUSH_FF:  k = K_PUSH;
      OP_STORE_89: k = K_STORE;
      OP_LOAD_8B:  k = K_LOAD;
      default:     k = K_OTHER;
    endcase
    return k;
  endfunction

  // One bit per register the entry will write; stores write nothing.
  function automatic logic [15:0] dest_mask(input op_kind_e k,
                                            input logic [3:0] reg_byte,
                                            input logic [3:0] rm_byte);
    logic [15:0] m;
    m = '0;
    case (k)
      K_MUL: begin
        m[REG_RAX] = 1'b1;
        m[REG_RDX] = 1'b1;
      end
      K_PUSH:  m[REG_RSP]  = 1'b1;
      K_LOAD:  m[reg_byte] = 1'b1;
      K_OTHER: m[rm_byte]  = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mod_wb_sequencer.sv
// Write-back sequencer: turns one EX/WB entry into up to two register-file writes or a store-completion wait.
// Latency: first write issues the cycle after accept; 0xF7 issues its second write one cycle later.
// Backpressure: in_ready only in IDLE, so one entry is held at a time; a store waits on mem_store_done up to STORE_TIMEOUT cycles.
module mod_wb_sequencer
  import mod_wb_sequencer_pkg::*;
#(
  parameter int unsigned STORE_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_opcode,
  input  logic [3:0]  in_regByte,
  input  logic [3:0]  in_rmByte,
  input  logic [63:0] in_alu_result,
  input  logic [63:0] in_alu_ext_result,
  input  logic        in_sim_end,
  input  logic [63:0] rsp_value,
  input  logic        mem_store_done,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic [15:0] busy_mask,
  output logic        store_done,
  output logic        sim_done,
  output logic        store_err
);

  // Counter only has to reach STORE_TIMEOUT-1: the last waiting cycle decides the timeout.
  localparam int unsigned CNT_W     = (STORE_TIMEOUT < 2) ? 1 : $clog2(STORE_TIMEOUT);
  localparam int unsigned TO_LAST_I = (STORE_TIMEOUT == 0) ? 0 : STORE_TIMEOUT - 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

  wb_state_e        state_q, state_d;
  wb_entry_t        entry_q;
  logic [15:0]      busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sim_done_q;
  logic             store_err_q;

  op_kind_e         in_kind;
  logic             accept;
  logic             timeout;
  wb_state_e        finish_state;

  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [63:0]      wr_data;
  logic [15:0]      wr_clr;
  logic             store_pulse;
  logic             to_err;

  assign in_kind      = decode_op(in_opcode);
  assign in_ready     = (state_q == ST_IDLE) && !reset;
  assign accept       = in_valid && in_ready;
  assign timeout      = (cnt_q == TO_LAST);
  assign finish_state = entry_q.sim_end ? ST_HALT : ST_IDLE;

  // Next-state decode and per-state write/pulse generation.
  always_comb begin
    state_d     = state_q;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    wr_clr      = '0;
    store_pulse = 1'b0;
    to_err      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = (in_kind == K_STORE) ? ST_STORE_WAIT : ST_WR0;
        end
      end
      ST_WR0: begin
        wr_en = 1'b1;
        case (entry_q.kind)
          K_MUL: begin
            wr_addr = REG_RAX;
            wr_data = entry_q.alu_result;
            state_d = ST_WR1;
          end
          K_PUSH: begin
            // RSP is read live here so a write-back that landed after accept is honoured.
            wr_addr     = REG_RSP;
            wr_data     = rsp_value - PUSH_STEP;
            store_pulse = 1'b1;
            state_d     = finish_state;
          end
          K_LOAD: begin
            wr_addr = entry_q.reg_byte;
            wr_data = entry_q.alu_result;
            state_d = finish_state;
          end
          default: begin
            wr_addr = entry_q.rm_byte;
            wr_data = entry_q.alu_result;
            state_d = finish_state;
          end
        endcase
        wr_clr[wr_addr] = 1'b1;
      end
      ST_WR1: begin
        wr_en           = 1'b1;
        wr_addr         = REG_RDX;
        wr_data         = entry_q.alu_ext_result;
        wr_clr[REG_RDX] = 1'b1;
        state_d         = finish_state;
      end
      ST_STORE_WAIT: begin
        // A completion in the final waiting cycle still counts as success.
        if (mem_store_done) begin
          store_pulse = 1'b1;
          state_d     = finish_state;
        end else if (timeout) begin
          to_err  = 1'b1;
          state_d = finish_state;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset overrides everything in its cycle, so nothing leaks onto the write port while it is high.
  assign rf_we      = wr_en && !reset;
  assign rf_waddr   = rf_we ? wr_addr : 4'd0;
  assign rf_wdata   = rf_we ? wr_data : 64'd0;
  assign store_done = store_pulse && !reset;
  assign busy_mask  = busy_q;
  assign sim_done   = sim_done_q;
  assign store_err  = store_err_q;

  // State, held entry, scoreboard mask, store-wait counter and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      entry_q     <= '0;
      busy_q      <= '0;
      cnt_q       <= '0;
      sim_done_q  <= 1'b0;
      store_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        entry_q <= '{kind:           in_kind,
                     reg_byte:       in_regByte,
                     rm_byte:        in_rmByte,
                     alu_result:     in_alu_result,
                     alu_ext_result: in_alu_ext_result,
                     sim_end:        in_sim_end};
        busy_q  <= dest_mask(in_kind, in_regByte, in_rmByte);
      end else if (wr_en) begin
        busy_q <= busy_q & ~wr_clr;
      end
      if ((state_q == ST_STORE_WAIT) && (state_d == ST_STORE_WAIT)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
      if (to_err) begin
        store_err_q <= 1'b1;
      end
      if (state_d == ST_HALT) begin
        sim_done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_wb_sequencer.sv
// Scoreboard bench for mod_wb_sequencer: directed entries push expected writes/pulses, a monitor pops and compares.
// Latency: checks writes at WR0/WR1 cycles following each accept.
// Backpressure: stimulus waits (bounded) for in_ready before presenting each entry.
module tb_mod_wb_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_opcode;
  logic [3:0]  in_regByte;
  logic [3:0]  in_rmByte;
  logic [63:0] in_alu_result;
  logic [63:0] in_alu_ext_result;
  logic        in_sim_end;
  logic [63:0] rsp_value;
  logic        mem_store_done;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [15:0] busy_mask;
  logic        store_done;
  logic        sim_done;
  logic        store_err;

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
    logic [15:0] busy;
  } wr_exp_t;

  wr_exp_t wr_q[$];
  bit      sd_q[$];   // one entry per expected store_done; value = rf_we expected in that cycle

  int n_tests = 0;
  int n_fail  = 0;

  mod_wb_sequencer #(.STORE_TIMEOUT(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_opcode         (in_opcode),
    .in_regByte        (in_regByte),
    .in_rmByte         (in_rmByte),
    .in_alu_result     (in_alu_result),
    .in_alu_ext_result (in_alu_ext_result),
    .in_sim_end        (in_sim_end),
    .rsp_value         (rsp_value),
    .mem_store_done    (mem_store_done),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .busy_mask         (busy_mask),
    .store_done        (store_done),
    .sim_done          (sim_done),
    .store_err         (store_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [63:0] d, input logic [15:0] b);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    e.busy = b;
    wr_q.push_back(e);
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one entry; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] op, input logic [3:0] rb, input logic [3:0] mb,
                      input logic [63:0] res, input logic [63:0] ext, input logic se);
    bit seen;
    seen              = 1'b0;
    in_valid          = 1'b1;
    in_opcode         = op;
    in_regByte        = rb;
    in_rmByte         = mb;
    in_alu_result     = res;
    in_alu_ext_result = ext;
    in_sim_end        = se;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("accept_ready", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sequencer back at rest: nothing busy, ready, every expectation consumed.
  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_busy"},  64'(busy_mask), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_wrq"},   64'(wr_q.size()), 64'd0);
    check({tag, "_sdq"},   64'(sd_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write and store_done pulse must match the head of its queue.
  initial begin : monitor
    wr_exp_t e;
    bit      w;
    forever begin
      @(negedge clk);
      if (rf_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write_addr", 64'(rf_waddr), 64'hDEAD);
        end else begin
          e = wr_q.pop_front();
          check("wr_addr", 64'(rf_waddr), 64'(e.addr));
          check("wr_data", rf_wdata, e.data);
          check("wr_busy", 64'(busy_mask), 64'(e.busy));
        end
      end else begin
        check("idle_waddr", 64'(rf_waddr), 64'd0);
        check("idle_wdata", rf_wdata, 64'd0);
      end
      if (store_done) begin
        if (sd_q.size() == 0) begin
          check("unexpected_store_done", 64'(store_done), 64'd0);
        end else begin
          w = sd_q.pop_front();
          check("sd_with_write", 64'(rf_we), 64'(w));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset             = 1'b1;
    in_valid          = 1'b0;
    in_opcode         = 8'h00;
    in_regByte        = 4'd0;
    in_rmByte         = 4'd0;
    in_alu_result     = 64'd0;
    in_alu_ext_result = 64'd0;
    in_sim_end        = 1'b0;
    rsp_value         = 64'd0;
    mem_store_done    = 1'b0;
    settle(3);
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_ready",     64'(in_ready), 64'd1);
    check("rst_we",        64'(rf_we), 64'd0);
    check("rst_busy",      64'(busy_mask), 64'd0);
    check("rst_sim_done",  64'(sim_done), 64'd0);
    check("rst_store_err", 64'(store_err), 64'd0);
    check("rst_store_done",64'(store_done), 64'd0);
    settle(1);

    // 0xF7: r0=5 then r2=7, busy 0x5 -> 0x4 -> 0x0.
    push_wr(4'd0, 64'h5, 16'h0005);
    push_wr(4'd2, 64'h7, 16'h0004);
    send(8'hF7, 4'd0, 4'd0, 64'h5, 64'h7, 1'b0);
    settle(2);
    check_idle("mul");

    // 0xFF with RSP=0: wraps to ...F8; RSP changed after accept must be the one used.
    push_wr(4'd4, 64'hFFFF_FFFF_FFFF_FFF8, 16'h0010);
    sd_q.push_back(1'b1);
    rsp_value = 64'h0000_0000_0000_DEAD;
    send(8'hFF, 4'd0, 4'd0, 64'h0, 64'h0, 1'b0);
    rsp_value = 64'h0;
    settle(1);
    check_idle("push0");

    push_wr(4'd4, 64'h0000_0000_0000_0FF8, 16'h0010);
    sd_q.push_back(1'b1);
    rsp_value = 64'h1234;
    send(8'hFF, 4'd7, 4'd7, 64'h99, 64'h0, 1'b0);
    rsp_value = 64'h1000;
    settle(1);
    check_idle("push1");

    // Stray mem_store_done while idle must be ignored.
    mem_store_done = 1'b1;
    settle(1);
    mem_store_done = 1'b0;

    // 0x89 completing in its third wait cycle.
    sd_q.push_back(1'b0);
    send(8'h89, 4'd1, 4'd2, 64'h0, 64'h0, 1'b0);
    @(negedge clk);
    check("st_wait_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    settle(1);
    mem_store_done = 1'b1;
    settle(1);
    mem_store_done = 1'b0;
    check_idle("store");

    // 0x89 timing out after 4 cycles.
    send(8'h89, 4'd1, 4'd2, 64'h0, 64'h0, 1'b0);
    settle(3);
    @(negedge clk);
    check("to_err_before",   64'(store_err), 64'd0);
    check("to_ready_before", 64'(in_ready), 64'd0);
    settle(1);
    @(negedge clk);
    check("to_err_after",   64'(store_err), 64'd1);
    check("to_ready_after", 64'(in_ready), 64'd1);
    settle(1);
    mem_store_done = 1'b1;
    settle(1);
    mem_store_done = 1'b0;
    check_idle("timeout");

    // Other opcode writes rmByte; 0x8B with regByte==rmByte writes that register.
    push_wr(4'd9, 64'h0000_0000_AAAA_5555, 16'h0200);
    send(8'h01, 4'd3, 4'd9, 64'h0000_0000_AAAA_5555, 64'h0, 1'b0);
    settle(1);
    check_idle("other");

    push_wr(4'd15, 64'hFFFF_0000_FFFF_0000, 16'h8000);
    send(8'h00, 4'd1, 4'd15, 64'hFFFF_0000_FFFF_0000, 64'h3, 1'b0);
    settle(1);
    check_idle("other15");

    push_wr(4'd6, 64'h1234_5678_9ABC_DEF0, 16'h0040);
    send(8'h8B, 4'd6, 4'd6, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0);
    settle(1);
    check_idle("load_same");

    // Reset during WR0 of 0xF7: no writes, everything cleared, sticky error too.
    send(8'hF7, 4'd0, 4'd0, 64'h11, 64'h22, 1'b0);
    reset = 1'b1;
    settle(1);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_busy",      64'(busy_mask), 64'd0);
    check("mrst_sim_done",  64'(sim_done), 64'd0);
    check("mrst_store_err", 64'(store_err), 64'd0);
    check("mrst_ready",     64'(in_ready), 64'd1);
    settle(3);
    check_idle("mrst");

    // 0x8B with sim_end: write r3 then halt, ignoring further entries.
    push_wr(4'd3, 64'hCAFE, 16'h0008);
    send(8'h8B, 4'd3, 4'd9, 64'hCAFE, 64'h0, 1'b1);
    settle(1);
    in_valid      = 1'b1;
    in_opcode     = 8'hF7;
    in_alu_result = 64'h77;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("halt_sim_done", 64'(sim_done), 64'd1);
      check("halt_ready",    64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    settle(1);
    reset = 1'b0;
    @(negedge clk);
    check("post_halt_sim_done", 64'(sim_done), 64'd0);
    check("post_halt_ready",    64'(in_ready), 64'd1);
    settle(1);
    check_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
